// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a variable-latency instruction memory
// and presents one instruction at a time to the control unit, with stall and redirect.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_ready,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [ADDR_W-1:0]  pc_out
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  pc_reg, pc_next;
   logic [ADDR_W-1:0]  pc_out_reg, pc_out_next;
   logic [INSTR_W-1:0] instr_reg, instr_next;
   logic               valid_reg, valid_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         pc_reg     <= RESET_PC;
         pc_out_reg <= '0;
         instr_reg  <= '0;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         pc_out_reg <= pc_out_next;
         instr_reg  <= instr_next;
         valid_reg  <= valid_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      pc_out_next = pc_out_reg;
      instr_next  = instr_reg;
      valid_next  = valid_reg;
      case (state_reg)
         IDLE: begin
            if (redirect_valid) pc_next = redirect_pc;
            state_next = REQ;
         end
         REQ: begin
            // Redirect wins over a response arriving in the same cycle.
            if (redirect_valid) begin
               pc_next    = redirect_pc;
               valid_next = 1'b0;
            end else if (imem_ready) begin
               instr_next  = imem_rdata;
               pc_out_next = pc_reg;
               valid_next  = 1'b1;
               pc_next     = pc_reg + ADDR_W'(PC_STEP);
               state_next  = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_next    = redirect_pc;
               valid_next = 1'b0;
               state_next = REQ;
            end else if (!stall) begin
               valid_next = 1'b0;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign imem_req    = (state_reg == REQ);
   assign imem_addr   = pc_reg;
   assign instr_valid = valid_reg;
   assign instr       = instr_reg;
   assign opcode      = instr_reg[INSTR_W-1 -: 4];
   assign pc_out      = pc_out_reg;

endmodule
